// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types and sizing helpers for the icache SCM write path
package icache_pkg;

  typedef enum logic [1:0] {
    SWEEP     = 2'd0,
    DONE      = 2'd1,
    OPERATIVE = 2'd2
  } scm_wctrl_state_t;

  function automatic int nb_sets(input int addr_width);
    return 1 << addr_width;
  endfunction

  // The sweep visits every bank of every set: bank index in the low bits, set above it.
  function automatic int sweep_cnt_width(input int nb_banks, input int addr_width);
    return $clog2(nb_banks) + addr_width;
  endfunction

endpackage

// File: rtl/icache_rr_arbiter.sv
// rtl/icache_rr_arbiter.sv - round-robin arbiter, priority starts at ptr, one-hot and binary grant
module icache_rr_arbiter #(
  parameter int NB_REQ = 4
) (
  input  logic [NB_REQ-1:0]         req,
  input  logic [$clog2(NB_REQ)-1:0] ptr,
  output logic [NB_REQ-1:0]         gnt,
  output logic [$clog2(NB_REQ)-1:0] idx
);

  localparam int IDX_W = $clog2(NB_REQ);

  logic             found;
  logic [IDX_W-1:0] cand;

  // NB_REQ is a power of two, so the index sum wraps naturally.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/icache_scm_write_ctrl.sv
// rtl/icache_scm_write_ctrl.sv - arbitrates bank refills onto the shared SCM write port and runs invalidation sweeps
module icache_scm_write_ctrl
  import icache_pkg::*;
#(
  parameter int NB_BANKS       = 4,
  parameter int NB_WAYS        = 4,
  parameter int SCM_ADDR_WIDTH = 4,
  parameter int TAG_WIDTH      = 6,
  parameter int DATA_WIDTH     = 128
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        flush_req_i,
  output logic                                        flush_ack_o,
  output logic                                        icache_flushing_o,
  input  logic [NB_BANKS-1:0]                         bank_write_req_i,
  input  logic [NB_BANKS*SCM_ADDR_WIDTH-1:0]          bank_write_addr_i,
  input  logic [NB_BANKS*$clog2(NB_BANKS)-1:0]        bank_write_dest_i,
  input  logic [NB_BANKS*NB_WAYS-1:0]                 bank_write_way_i,
  input  logic [NB_BANKS*(TAG_WIDTH+DATA_WIDTH)-1:0]  bank_write_wdata_i,
  output logic [NB_BANKS-1:0]                         bank_write_gnt_o,
  output logic                                        scm_write_req_o,
  output logic [SCM_ADDR_WIDTH-1:0]                   scm_write_addr_o,
  output logic [$clog2(NB_BANKS)-1:0]                 scm_write_dest_o,
  output logic [NB_WAYS-1:0]                          scm_write_way_o,
  output logic [TAG_WIDTH+DATA_WIDTH-1:0]             scm_write_wdata_o
);

  localparam int BANK_W = $clog2(NB_BANKS);
  localparam int CNT_W  = sweep_cnt_width(NB_BANKS, SCM_ADDR_WIDTH);
  localparam int WD_W   = TAG_WIDTH + DATA_WIDTH;

  scm_wctrl_state_t state, state_nxt;

  logic [CNT_W-1:0]          sweep_cnt;
  logic [BANK_W-1:0]         rr_ptr;
  logic                      flush_pend, flush_pend_nxt;
  logic [NB_BANKS-1:0]       arb_gnt;
  logic [BANK_W-1:0]         arb_idx;
  logic                      gnt_en;
  logic                      issue_wr;
  logic                      rr_adv;
  logic [SCM_ADDR_WIDTH-1:0] issue_addr;
  logic [BANK_W-1:0]         issue_dest;
  logic [NB_WAYS-1:0]        issue_way;
  logic [WD_W-1:0]           issue_wdata;

  icache_rr_arbiter #(
    .NB_REQ (NB_BANKS)
  ) u_arb (
    .req (bank_write_req_i),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Requests seen while sweeping or flushing are granted so no bank stalls, but nothing is written.
  assign bank_write_gnt_o = (rst_n && gnt_en) ? arb_gnt : '0;

  always_comb begin
    state_nxt         = state;
    flush_pend_nxt    = flush_pend;
    gnt_en            = 1'b0;
    issue_wr          = 1'b0;
    rr_adv            = 1'b0;
    flush_ack_o       = 1'b0;
    icache_flushing_o = 1'b0;
    issue_addr        = bank_write_addr_i[arb_idx*SCM_ADDR_WIDTH +: SCM_ADDR_WIDTH];
    issue_dest        = bank_write_dest_i[arb_idx*BANK_W +: BANK_W];
    issue_way         = bank_write_way_i[arb_idx*NB_WAYS +: NB_WAYS];
    issue_wdata       = bank_write_wdata_i[arb_idx*WD_W +: WD_W];
    case (state)
      SWEEP: begin
        icache_flushing_o = 1'b1;
        gnt_en            = 1'b1;
        issue_wr          = 1'b1;
        issue_addr        = sweep_cnt[CNT_W-1:BANK_W];
        issue_dest        = sweep_cnt[BANK_W-1:0];
        issue_way         = '1;
        issue_wdata       = '0;
        if (flush_req_i) flush_pend_nxt = 1'b1;
        if (&sweep_cnt)  state_nxt      = DONE;
      end
      DONE: begin
        flush_ack_o    = flush_pend;
        flush_pend_nxt = flush_req_i;
        state_nxt      = flush_req_i ? SWEEP : OPERATIVE;
      end
      OPERATIVE: begin
        gnt_en = 1'b1;
        if (flush_req_i) begin
          state_nxt      = SWEEP;
          flush_pend_nxt = 1'b1;
        end else if (|arb_gnt) begin
          issue_wr = 1'b1;
          rr_adv   = 1'b1;
        end
      end
      default: state_nxt = SWEEP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= SWEEP;
      sweep_cnt         <= '0;
      rr_ptr            <= '0;
      flush_pend        <= 1'b0;
      scm_write_req_o   <= 1'b0;
      scm_write_addr_o  <= '0;
      scm_write_dest_o  <= '0;
      scm_write_way_o   <= '0;
      scm_write_wdata_o <= '0;
    end else begin
      state           <= state_nxt;
      flush_pend      <= flush_pend_nxt;
      scm_write_req_o <= issue_wr;
      if (state == SWEEP) sweep_cnt <= sweep_cnt + 1'b1;
      if (rr_adv)         rr_ptr    <= arb_idx + 1'b1;
      if (issue_wr) begin
        scm_write_addr_o  <= issue_addr;
        scm_write_dest_o  <= issue_dest;
        scm_write_way_o   <= issue_way;
        scm_write_wdata_o <= issue_wdata;
      end
    end
  end

endmodule

// File: tb/tb_icache_scm_write_ctrl.sv
// tb/tb_icache_scm_write_ctrl.sv - scoreboard bench for icache_scm_write_ctrl
module tb_icache_scm_write_ctrl;

  localparam int NB = 4;
  localparam int AW = 4;
  localparam int WD = 134;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           flush_req_i;
  logic           flush_ack_o;
  logic           icache_flushing_o;
  logic [NB-1:0]  bank_write_req_i;
  logic [NB*AW-1:0] bank_write_addr_i;
  logic [NB*2-1:0]  bank_write_dest_i;
  logic [NB*4-1:0]  bank_write_way_i;
  logic [NB*WD-1:0] bank_write_wdata_i;
  logic [NB-1:0]  bank_write_gnt_o;
  logic           scm_write_req_o;
  logic [AW-1:0]  scm_write_addr_o;
  logic [1:0]     scm_write_dest_o;
  logic [3:0]     scm_write_way_o;
  logic [WD-1:0]  scm_write_wdata_o;

  icache_scm_write_ctrl #(
    .NB_BANKS(4), .NB_WAYS(4), .SCM_ADDR_WIDTH(4), .TAG_WIDTH(6), .DATA_WIDTH(128)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush_req_i(flush_req_i), .flush_ack_o(flush_ack_o),
    .icache_flushing_o(icache_flushing_o), .bank_write_req_i(bank_write_req_i),
    .bank_write_addr_i(bank_write_addr_i), .bank_write_dest_i(bank_write_dest_i),
    .bank_write_way_i(bank_write_way_i), .bank_write_wdata_i(bank_write_wdata_i),
    .bank_write_gnt_o(bank_write_gnt_o), .scm_write_req_o(scm_write_req_o),
    .scm_write_addr_o(scm_write_addr_o), .scm_write_dest_o(scm_write_dest_o),
    .scm_write_way_o(scm_write_way_o), .scm_write_wdata_o(scm_write_wdata_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [1:0]    dest;
    logic [3:0]    way;
    logic [WD-1:0] wdata;
    int            cyc;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  acks = 0;
  int  exp_acks = 0;
  int  ptr = 0;
  bit            pend[NB];
  logic [AW-1:0] b_addr[NB];
  logic [1:0]    b_dest[NB];
  logic [3:0]    b_way[NB];
  logic [WD-1:0] b_wd[NB];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every visible SCM write must be the next expected one, on its cycle.
  always @(negedge clk) begin
    wr_t e;
    if (flush_ack_o === 1'b1) begin
      acks++;
      check("ack_while_flushing", 160'(icache_flushing_o), 160'(0));
    end
    if (scm_write_req_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %0h dest %0h at cycle %0d expected no write",
                 scm_write_addr_o, scm_write_dest_o, cyc);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr",  160'(scm_write_addr_o),  160'(e.addr));
        check("wr_dest",  160'(scm_write_dest_o),  160'(e.dest));
        check("wr_way",   160'(scm_write_way_o),   160'(e.way));
        check("wr_wdata", 160'(scm_write_wdata_o), 160'(e.wdata));
        check("wr_cycle", 160'(cyc),               160'(e.cyc));
      end
    end
  end

  task automatic push_sweep(input int base);
    wr_t e;
    for (int k = 0; k < NB * 16; k++) begin
      e.addr  = 4'(k / NB);
      e.dest  = 2'(k % NB);
      e.way   = 4'hF;
      e.wdata = '0;
      e.cyc   = base + k;
      exp_q.push_back(e);
    end
  endtask

  task automatic arm(input int b);
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    pend[b]   = 1'b1;
    b_addr[b] = 4'($urandom_range(15));
    b_dest[b] = 2'($urandom_range(3));
    b_way[b]  = 4'b1 << $urandom_range(3);
    b_wd[b]   = r[WD-1:0];
  endtask

  function automatic int pick();
    for (int i = 0; i < NB; i++)
      if (pend[(ptr + i) % NB]) return (ptr + i) % NB;
    return -1;
  endfunction

  // One clock of stimulus; entered and left at posedge+1.
  task automatic cycle(input bit flush, input bit sweeping);
    int g;
    logic [NB-1:0] eg;
    wr_t e;
    for (int i = 0; i < NB; i++) begin
      bank_write_req_i[i]              = pend[i];
      bank_write_addr_i[i*AW +: AW]    = b_addr[i];
      bank_write_dest_i[i*2 +: 2]      = b_dest[i];
      bank_write_way_i[i*4 +: 4]       = b_way[i];
      bank_write_wdata_i[i*WD +: WD]   = b_wd[i];
    end
    flush_req_i = flush;
    #2;
    g  = pick();
    eg = (g < 0) ? '0 : (NB'(1) << g);
    check("gnt", 160'(bank_write_gnt_o), 160'(eg));
    if (g >= 0) begin
      pend[g] = 1'b0;
      if (!sweeping && !flush) begin
        e.addr = b_addr[g]; e.dest = b_dest[g]; e.way = b_way[g]; e.wdata = b_wd[g];
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
        ptr = (g + 1) % NB;
      end
    end
    if (flush && !sweeping) push_sweep(cyc + 2);
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(input int pulse_at, input int rst_at, input bit exp_ack);
    int n;
    n = 0;
    while (icache_flushing_o === 1'b1 && n < 200) begin
      if (n == rst_at) return;
      if (!pend[3] && $urandom_range(3) == 0) arm(3);
      cycle(n == pulse_at, 1'b1);
      n++;
    end
    check("sweep_len", 160'(n), 160'(64));
    check("done_ack", 160'(flush_ack_o), 160'(exp_ack));
    cycle(1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs();
    bank_write_req_i = '1;
    #1;
    check("rst_req",      160'(scm_write_req_o),   160'(0));
    check("rst_addr",     160'(scm_write_addr_o),  160'(0));
    check("rst_dest",     160'(scm_write_dest_o),  160'(0));
    check("rst_way",      160'(scm_write_way_o),   160'(0));
    check("rst_wdata",    160'(scm_write_wdata_o), 160'(0));
    check("rst_flushing", 160'(icache_flushing_o), 160'(1));
    check("rst_ack",      160'(flush_ack_o),       160'(0));
    check("rst_gnt",      160'(bank_write_gnt_o),  160'(0));
    bank_write_req_i = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    flush_req_i = 1'b0;
    bank_write_req_i = '0;
    bank_write_addr_i = '0;
    bank_write_dest_i = '0;
    bank_write_way_i = '0;
    bank_write_wdata_i = '0;
    for (int i = 0; i < NB; i++) begin
      pend[i] = 1'b0; b_addr[i] = '0; b_dest[i] = '0; b_way[i] = '0; b_wd[i] = '0;
    end

    // Reset release: full sweep, no ack.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    push_sweep(cyc + 1);
    rst_n = 1'b1;
    run_sweep(-1, -1, 1'b0);

    // Banks 0 and 2 together from rr_ptr 0.
    arm(0); arm(2);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);

    // All banks hold requests: strict rotation.
    for (int c = 0; c < 8; c++) begin
      for (int b = 0; b < NB; b++) if (!pend[b]) arm(b);
      cycle(1'b0, 1'b0);
    end

    // Random refill traffic.
    for (int c = 0; c < 200; c++) begin
      for (int b = 0; b < NB; b++) if (!pend[b] && $urandom_range(1) == 1) arm(b);
      cycle(1'b0, 1'b0);
    end
    repeat (6) cycle(1'b0, 1'b0);

    // Flush collides with a bank1 request: granted, dropped, then sweep and ack.
    arm(1);
    cycle(1'b1, 1'b0);
    run_sweep(-1, -1, 1'b1);
    exp_acks++;
    arm(1);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);

    // Second flush pulse mid-sweep merges into the running sweep.
    cycle(1'b1, 1'b0);
    run_sweep(30, -1, 1'b1);
    exp_acks++;
    cycle(1'b0, 1'b0);

    // Reset at sweep write 40 restarts a full sweep with no ack.
    cycle(1'b1, 1'b0);
    run_sweep(-1, 41, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs();
    exp_q.delete();
    for (int i = 0; i < NB; i++) pend[i] = 1'b0;
    ptr = 0;
    push_sweep(cyc + 1);
    rst_n = 1'b1;
    run_sweep(-1, -1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0);

    check("queue_drained", 160'(exp_q.size()), 160'(0));
    check("ack_count", 160'(acks), 160'(exp_acks));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
